// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, tag widths
// and the buffered-operation payload held in the skid register.
package exec_pkg;

    localparam int unsigned CTL_W  = 4;
    localparam int unsigned RD_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SH_W   = 5;

    typedef enum logic [CTL_W-1:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SHL  = 4'b0101,
        OP_SHR  = 4'b0110,
        OP_ROTR = 4'b0111
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [CTL_W-1:0]  aluctl;
        logic              setflags;
        logic [RD_W-1:0]   rd;
    } exec_op_t;

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational ALU: arithmetic, logic, shifts and rotate-right.
// Opcodes outside the defined set produce zero.
module exec_stage_alu
    import exec_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [CTL_W-1:0] aluctl,
    output logic [N-1:0]     result_c
);

    logic [SH_W-1:0] shamt;

    assign shamt = b[SH_W-1:0];

    always_comb begin
        result_c = '0;
        case (aluctl)
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = a - b;
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_XOR:  result_c = a ^ b;
            OP_SHL:  result_c = a << shamt;
            OP_SHR:  result_c = a >> shamt;
            // a zero rotate shifts the left half out by the full width, leaving a
            OP_ROTR: result_c = (a >> shamt) | (a << (N - 32'(shamt)));
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: one output register plus one skid entry, valid/ready on both
// sides, flush, and an architectural Z/N flag register updated on drain.
module exec_stage
    import exec_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [CTL_W-1:0] in_aluctl,
    input  logic             in_setflags,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_z,
    output logic             out_n,
    output logic             flag_z,
    output logic             flag_n
);

    logic       running_q;
    logic       skid_valid_q;
    exec_op_t   skid_q;
    logic       out_setflags_q;

    logic       out_valid_d;
    logic       skid_valid_d;
    logic       load_out;
    logic       load_skid;
    logic       load_flags;
    logic       drain;
    logic       accept;

    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [CTL_W-1:0] alu_ctl;
    logic [N-1:0]     alu_result_c;
    logic             src_setflags;
    logic [RD_W-1:0]  src_rd;

    // running_q keeps in_ready low through reset and the release cycle
    assign in_ready = running_q & ~skid_valid_q & ~flush;
    assign drain    = out_valid & out_ready;
    assign accept   = in_valid & in_ready;

    // The skid entry is always older than the input, so it feeds the ALU first
    assign alu_a        = skid_valid_q ? N'(skid_q.a) : in_a;
    assign alu_b        = skid_valid_q ? N'(skid_q.b) : in_b;
    assign alu_ctl      = skid_valid_q ? skid_q.aluctl : in_aluctl;
    assign src_setflags = skid_valid_q ? skid_q.setflags : in_setflags;
    assign src_rd       = skid_valid_q ? skid_q.rd : in_rd;

    exec_stage_alu #(.N(N)) u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .aluctl   (alu_ctl),
        .result_c (alu_result_c)
    );

    // Occupancy next-state and register load enables
    always_comb begin
        out_valid_d  = out_valid;
        skid_valid_d = skid_valid_q;
        load_out     = 1'b0;
        load_skid    = 1'b0;
        load_flags   = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (drain) begin
                load_flags  = out_setflags_q;
                out_valid_d = 1'b0;
            end
            if (!out_valid || drain) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                    load_out     = 1'b1;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    load_out    = 1'b1;
                end
            end else if (accept) begin
                skid_valid_d = 1'b1;
                load_skid    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            running_q      <= 1'b0;
            out_valid      <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_q         <= '0;
            out_setflags_q <= 1'b0;
            out_result     <= '0;
            out_rd         <= '0;
            out_z          <= 1'b0;
            out_n          <= 1'b0;
            flag_z         <= 1'b0;
            flag_n         <= 1'b0;
        end else begin
            running_q    <= 1'b1;
            out_valid    <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            if (load_out) begin
                out_result     <= alu_result_c;
                out_rd         <= src_rd;
                out_z          <= (alu_result_c == '0);
                out_n          <= alu_result_c[N-1];
                out_setflags_q <= src_setflags;
            end
            if (load_skid) begin
                skid_q <= '{a: DATA_W'(in_a), b: DATA_W'(in_b), aluctl: in_aluctl,
                            setflags: in_setflags, rd: in_rd};
            end
            if (load_flags) begin
                flag_z <= out_z;
                flag_n <= out_n;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed scenarios then randomized traffic,
// checked against a queue-based occupancy/flag model and an arithmetic ALU model.
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_aluctl = '0;
    logic        in_setflags = 1'b0;
    logic [3:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_z, out_n, flag_z, flag_n;

    exec_stage #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_aluctl  (in_aluctl),
        .in_setflags(in_setflags),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_z      (out_z),
        .out_n      (out_n),
        .flag_z     (flag_z),
        .flag_n     (flag_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        z;
        logic        n;
        logic        sf;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   m_run = 1'b0;
    bit   m_fz  = 1'b0;
    bit   m_fn  = 1'b0;
    bit   rmode = 1'b0;

    function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        logic [31:0] r;
        int          s;
        s = int'(b[4:0]);
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << s;
            4'd6: r = a >> s;
            4'd7: begin
                r = a;
                for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: compare at negedge, then advance the model across the coming edge
    bit          exp_rdy;
    exp_t        e_pop;
    exp_t        e_new;
    always @(negedge clk) begin
        exp_rdy = m_run && !flush && (q.size() < 2);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("flag_z", 32'(flag_z), 32'(m_fz));
        chk("flag_n", 32'(flag_n), 32'(m_fn));
        if (!m_run) begin
            chk("rst_result", out_result, 32'd0);
            chk("rst_rd", 32'(out_rd), 32'd0);
            chk("rst_z", 32'(out_z), 32'd0);
            chk("rst_n", 32'(out_n), 32'd0);
        end
        if (q.size() != 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_z", 32'(out_z), 32'(q[0].z));
            chk("out_n", 32'(out_n), 32'(q[0].n));
        end
        if (!rst) begin
            q.delete();
            m_fz  = 1'b0;
            m_fn  = 1'b0;
            m_run = 1'b0;
        end else begin
            m_run = 1'b1;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) begin
                    e_pop = q.pop_front();
                    if (e_pop.sf) begin
                        m_fz = e_pop.z;
                        m_fn = e_pop.n;
                    end
                end
                if (in_valid && exp_rdy) begin
                    e_new.res = ref_alu(in_a, in_b, in_aluctl);
                    e_new.rd  = in_rd;
                    e_new.z   = (e_new.res == 32'd0);
                    e_new.n   = e_new.res[31];
                    e_new.sf  = in_setflags;
                    q.push_back(e_new);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic sf, input logic [3:0] rd);
        in_valid    = 1'b1;
        in_a        = a;
        in_b        = b;
        in_aluctl   = op;
        in_setflags = sf;
        in_rd       = rd;
    endtask

    task automatic wait_accept();
        int n;
        bit ok;
        n = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rmode) begin
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 31) == 0);
            end
            if (ok) break;
            n++;
            if (n > 200) begin
                compared++;
                mismatched++;
                $display("FAIL accept_timeout: got no acceptance expected one within 200 cycles");
                break;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic sf, input logic [3:0] rd);
        drive(a, b, op, sf, rd);
        wait_accept();
    endtask

    initial begin
        rst = 1'b0;
        out_ready = 1'b1;
        cycles(3);
        rst = 1'b1;
        cycles(2);

        // single ADD with flags
        issue(32'h1, 32'h1, 4'b0000, 1'b1, 4'd1);
        in_valid = 1'b0;
        cycles(3);

        // wrap and rotate
        issue(32'h0, 32'h1, 4'b0001, 1'b1, 4'd2);
        issue(32'h1, 32'h1, 4'b0111, 1'b0, 4'd3);
        in_valid = 1'b0;
        cycles(3);

        // backpressure: third op waits until the output drains
        out_ready = 1'b0;
        issue(32'h10, 32'h3, 4'b0101, 1'b0, 4'd4);
        issue(32'hF0, 32'h4, 4'b0110, 1'b1, 4'd5);
        drive(32'hFF00, 32'h0F0F, 4'b0100, 1'b0, 4'd6);
        cycles(3);
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        cycles(4);

        // streaming at one op per cycle
        for (int i = 0; i < 8; i++)
            issue($urandom, $urandom, 4'($urandom_range(0, 7)), 1'b1, 4'(i));
        in_valid = 1'b0;
        cycles(3);

        // flush with both entries held and a simultaneous drain handshake
        out_ready = 1'b0;
        issue(32'h0, 32'h1, 4'b0001, 1'b1, 4'd7);
        issue(32'h0, 32'h0, 4'b0000, 1'b1, 4'd8);
        in_valid = 1'b0;
        cycles(2);
        flush = 1'b1;
        out_ready = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(3);

        // reset mid-stream, then an undefined opcode
        out_ready = 1'b0;
        issue(32'h5, 32'h7, 4'b0011, 1'b1, 4'd9);
        issue(32'h9, 32'h2, 4'b0000, 1'b1, 4'd10);
        in_valid = 1'b0;
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        out_ready = 1'b1;
        cycles(2);
        issue(32'h1234, 32'h5678, 4'b1010, 1'b1, 4'd11);
        in_valid = 1'b0;
        cycles(3);

        // randomized traffic with random backpressure and occasional flush
        rmode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            issue(a, b, 4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                cycles(1);
            end
        end
        rmode = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        cycles(5);
        chk("drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter N, default 32, SHALL set the operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  upstream (decode) offers an operation.
REQ-005 in_ready  output  1  stage accepts the operation this cycle.
REQ-006 in_a, in_b  input  N each  source operands.
REQ-007 in_aluctl  input  4  operation code, as used by Alu.
REQ-008 in_setflags  input  1  operation updates the flag register.
REQ-009 in_rd  input  4  destination register tag, passed through unchanged.
REQ-010 flush  input  1  discards all in-flight operations.
REQ-011 out_valid  output  1  result offered downstream (writeback).
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_result  output  N  registered ALU result.
REQ-014 out_rd  output  4  registered destination tag.
REQ-015 out_z, out_n  output  1 each  registered zero and negative flags of out_result.
REQ-016 flag_z, flag_n  output  1 each  architectural flag register.

Function
REQ-017 Acceptance SHALL occur when in_valid and in_ready are both high on a rising edge.
REQ-018 The output register SHALL hold one entry. A skid register SHALL hold one further entry, giving a total capacity of 2.
REQ-019 in_ready SHALL equal (skid empty) and (not flush), and SHALL be driven only from registered state and flush.
REQ-020 Latency: with the output register empty or draining, an accepted operation SHALL appear in the output register on the next edge, with out_valid high one cycle after acceptance.
REQ-021 When the output register is full and not draining, an accepted operation SHALL enter the skid register.
REQ-022 The skid entry SHALL move to the output register on the edge where the output drains, and SHALL take priority over new input, preserving program order.
REQ-023 The output SHALL drain when out_valid and out_ready are both high. Simultaneous drain and acceptance SHALL sustain 1 operation per cycle.
REQ-024 Contents of out_result, out_rd, out_z and out_n SHALL stay stable while out_valid is high and out_ready is low.
REQ-025 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHL by in_b[4:0], 0110 SHR logical, 0111 ROTR by in_b[4:0]. Codes 1000-1111 SHALL produce result 0.
REQ-026 ADD and SUB SHALL wrap modulo 2^N, with no carry or overflow output.
REQ-027 out_z SHALL be 1 iff result == 0. out_n SHALL equal result[N-1].
REQ-028 flag_z and flag_n SHALL load out_z and out_n on the edge where an entry with setflags=1 drains. Otherwise they SHALL hold.
REQ-029 Flush SHALL clear out_valid and the skid entry on the next edge. It SHALL take priority over acceptance and drain and SHALL leave the flags unchanged.
REQ-030 A drain handshake in the flush cycle SHALL not update the flags.

Reset
REQ-031 While rst is low at an edge, out_valid and the skid entry SHALL clear, and out_result, out_rd, out_z, out_n, flag_z and flag_n SHALL go to 0.
REQ-032 in_ready SHALL be 0 while rst is low and 1 on the first cycle after release.
REQ-033 Reset asserted mid-operation SHALL discard all entries without a flag update.

Structure
REQ-034 Package exec_pkg SHALL hold the opcode enum, the width constant 4 for aluctl and rd, and a struct of {a, b, aluctl, setflags, rd} used for the skid entry.
REQ-035 Combinational compute SHALL be the existing sub-module Alu, instantiated once and fed from the skid entry when valid, else from the inputs.

Verification
REQ-036 Single op: ADD a=0x00000001 b=0x00000001, setflags=1, out_ready=1 -> next cycle out_result=0x00000002, z=0, n=0; after drain flag_z=0, flag_n=0.
REQ-037 Wrap: SUB a=0 b=1 -> out_result=0xFFFFFFFF, out_n=1. ROTR a=0x00000001 b=1 -> 0x80000000.
REQ-038 Backpressure: out_ready=0 while 3 ops are offered -> in_ready low after the 2nd acceptance. Raising out_ready -> results emerge in order on consecutive cycles.
REQ-039 Streaming: out_ready=1 with in_valid held high for 8 cycles -> 8 results on 8 consecutive cycles, in_ready constantly 1.
REQ-040 Flush with 2 entries held and setflags=1 -> out_valid=0 next cycle, flags unchanged, in_ready=1.
REQ-041 Reset mid-stream and undefined opcode 1010 -> all outputs 0 after reset. The 1010 op yields result 0, out_z=1.
